// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the matmul datapath (feeder, multiplier, benches).
package matmul_pkg;

  typedef enum logic [1:0] {
    S_LOAD_X,
    S_LOAD_Y,
    S_START,
    S_WAIT
  } feeder_state_t;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF  = 6;
  localparam int VECTOR_SIZE_DEF = 8;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/matmul_feeder.sv
// Streams x then y vectors into the multiplier's write ports, pulses start, waits for done.
// Optional MATMUL_FEEDER_CYCLE_COUNT_EN adds a cycle_count port measuring S_WAIT duration.
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int VECTOR_SIZE = VECTOR_SIZE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] x_wr_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic                  y_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic                  start,
  input  logic                  done,
  output logic                  busy
`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VECTOR_SIZE - 1);

  feeder_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  armed_q, armed_d;
  logic                  x_we_d, y_we_d;

  logic [ADDR_WIDTH-1:0] x_addr_q, y_addr_q;
  logic [DATA_WIDTH-1:0] x_din_q, y_din_q;
  logic                  x_en_q, y_en_q;

  logic accept, last_beat, consume;

  assign in_ready  = (state_q == S_LOAD_X) || (state_q == S_LOAD_Y);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (idx_q == LAST_IDX);
  // done only counts once a low level has been seen in S_WAIT, so a stale high never ends a batch.
  assign consume   = (state_q == S_WAIT) && armed_q && done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_LOAD_X;
      idx_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD_X: if (last_beat) state_d = S_LOAD_Y;
      S_LOAD_Y: if (last_beat) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (consume) state_d = S_LOAD_X;
      default:  state_d = S_LOAD_X;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    armed_d = armed_q;
    x_we_d  = 1'b0;
    y_we_d  = 1'b0;
    if (accept) begin
      idx_d = last_beat ? '0 : idx_q + ADDR_WIDTH'(1);
    end
    unique case (state_q)
      S_LOAD_X: begin
        x_we_d = accept;
        if (accept) busy_d = 1'b1;
      end
      S_LOAD_Y: y_we_d = accept;
      S_START:  start_d = 1'b1;
      S_WAIT: begin
        if (consume) begin
          armed_d = 1'b0;
          busy_d  = 1'b0;
        end else if (!done) begin
          armed_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Address and data only move on an accepted beat; the enable alone marks gaps.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_en_q   <= 1'b0;
      x_addr_q <= '0;
      x_din_q  <= '0;
    end else begin
      x_en_q <= x_we_d;
      if (x_we_d) begin
        x_addr_q <= idx_q;
        x_din_q  <= in_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      y_en_q   <= 1'b0;
      y_addr_q <= '0;
      y_din_q  <= '0;
    end else begin
      y_en_q <= y_we_d;
      if (y_we_d) begin
        y_addr_q <= idx_q;
        y_din_q  <= in_data;
      end
    end
  end

  assign x_wr_en   = x_en_q;
  assign x_wr_addr = x_addr_q;
  assign x_din     = x_din_q;
  assign y_wr_en   = y_en_q;
  assign y_wr_addr = y_addr_q;
  assign y_din     = y_din_q;
  assign start     = start_q;
  assign busy      = busy_q;

`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d, cc_q, cc_d;

  // Captured value includes the consume edge itself, i.e. every edge sampled in S_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    cc_d  = cc_q;
    if (state_q == S_START)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = sat_inc32(cnt_q);
    if (consume)                cc_d  = sat_inc32(cnt_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      cc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      cc_q  <= cc_d;
    end
  end

  assign cycle_count = cc_q;
`endif

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder: expected writes queued at beat acceptance, popped at write-out.
// A second instance with VECTOR_SIZE=1 covers the single-element case.
module tb_matmul_feeder;
  import matmul_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = ADDR_WIDTH_DEF;
  localparam int VS = VECTOR_SIZE_DEF;

  typedef struct {
    bit            is_y;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] x_wr_addr, y_wr_addr;
  logic          x_wr_en, y_wr_en;
  logic [DW-1:0] x_din, y_din;
  logic          start;
  logic          done = 1'b1;
  logic          busy;

  logic [DW-1:0] in_data1 = '0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [AW-1:0] x_wr_addr1, y_wr_addr1;
  logic          x_wr_en1, y_wr_en1;
  logic [DW-1:0] x_din1, y_din1;
  logic          start1;
  logic          done1 = 1'b1;
  logic          busy1;

`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
  logic [31:0] cycle_count, cycle_count1;
`endif

  int  total = 0;
  int  bad = 0;
  int  start_cnt = 0;
  int  beat_n = 0;
  wr_t exp_q[$];

  always #5 clock = ~clock;

  matmul_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(VS)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x_wr_addr(x_wr_addr), .x_wr_en(x_wr_en), .x_din(x_din),
    .y_wr_addr(y_wr_addr), .y_wr_en(y_wr_en), .y_din(y_din),
    .start(start), .done(done), .busy(busy)
`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  matmul_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .x_wr_addr(x_wr_addr1), .x_wr_en(x_wr_en1), .x_din(x_din1),
    .y_wr_addr(y_wr_addr1), .y_wr_en(y_wr_en1), .y_din(y_din1),
    .start(start1), .done(done1), .busy(busy1)
`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
    , .cycle_count(cycle_count1)
`endif
  );

  // Write-port monitor: every enabled write must match the oldest expected beat.
  always @(negedge clock) begin
    if (reset) begin
      if (x_wr_en && y_wr_en) begin
        total++; bad++;
        $display("FAIL both_wr_en: x and y enables high together at %0t", $time);
      end else if (x_wr_en || y_wr_en) begin
        wr_t e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: y=%0b addr=%0d data=%h with nothing expected",
                   y_wr_en, y_wr_en ? y_wr_addr : x_wr_addr, y_wr_en ? y_din : x_din);
        end else begin
          e = exp_q.pop_front();
          if (y_wr_en !== e.is_y || (y_wr_en ? y_wr_addr : x_wr_addr) !== e.addr ||
              (y_wr_en ? y_din : x_din) !== e.data) begin
            bad++;
            $display("FAIL write: got y=%0b addr=%0d data=%h, expected y=%0b addr=%0d data=%h",
                     y_wr_en, y_wr_en ? y_wr_addr : x_wr_addr, y_wr_en ? y_din : x_din,
                     e.is_y, e.addr, e.data);
          end
        end
      end
      if (start) start_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the beat is accepted, in_valid left high.
  task automatic send(input logic [DW-1:0] d);
    int  budget = 0;
    wr_t e;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, budget);
    end else begin
      @(posedge clock);
      e.is_y = (beat_n >= VS);
      e.addr = AW'(beat_n % VS);
      e.data = d;
      exp_q.push_back(e);
      beat_n = (beat_n + 1) % (2 * VS);
      @(negedge clock);
    end
  endtask

  task automatic load_vectors(input bit gapped);
    for (int i = 0; i < 2 * VS; i++) begin
      send((i < VS) ? DW'(i + 1) : DW'(32'h10 + i - VS));
      if (gapped && i != 2 * VS - 1) begin
        in_valid = 1'b0;
        repeat (2) begin
          @(negedge clock);
          total++;
          if (x_wr_en !== 1'b0 || y_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL gap_wr_en: x=%0b y=%0b during gap, expected 0 0", x_wr_en, y_wr_en);
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Entered at the negedge where the final y write is presented.
  task automatic expect_start();
    total++;
    if (start !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL start_early: start=%0b in_ready=%0b during last y write, expected 0 0", start, in_ready);
    end
    @(negedge clock);
    total++;
    if (start !== 1'b1 || y_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL start_pulse: start=%0b y_wr_en=%0b after last y write, expected 1 0", start, y_wr_en);
    end
    @(negedge clock);
    total++;
    if (start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_width: start=%0b in_ready=%0b busy=%0b, expected 0 0 1", start, in_ready, busy);
    end
  endtask

  // done is stale-high on entry; drop it now, raise it gap cycles later.
  task automatic complete_batch(input int gap);
    done = 1'b0;
    repeat (gap) begin
      @(negedge clock);
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL wait_hold: in_ready=%0b busy=%0b in S_WAIT, expected 0 1", in_ready, busy);
      end
    end
    done = 1'b1;
    @(negedge clock);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_consume: in_ready=%0b busy=%0b after done, expected 1 0", in_ready, busy);
    end
`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
    total++;
    if (cycle_count !== 32'(gap + 2)) begin
      bad++;
      $display("FAIL cycle_count: got %0d, expected %0d", cycle_count, gap + 2);
    end
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || x_wr_en !== 1'b0 ||
        y_wr_en !== 1'b0 || x_wr_addr !== '0 || y_wr_addr !== '0 || x_din !== '0 || y_din !== '0) begin
      bad++;
      $display("FAIL %s: rdy=%0b busy=%0b start=%0b xen=%0b yen=%0b xa=%0d ya=%0d xd=%h yd=%h, expected 1 0 0 0 0 0 0 0 0",
               tag, in_ready, busy, start, x_wr_en, y_wr_en, x_wr_addr, y_wr_addr, x_din, y_din);
    end
`ifdef MATMUL_FEEDER_CYCLE_COUNT_EN
    total++;
    if (cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL %s_cycle_count: got %0d, expected 0", tag, cycle_count);
    end
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_values");
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_stream();
    int s0 = start_cnt;
    load_vectors(1'b0);
    expect_start();
    complete_batch(20);
    total++;
    if (start_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL stream_starts: got %0d start pulses, expected 1", start_cnt - s0);
    end
  endtask

  task automatic test_gaps();
    load_vectors(1'b1);
    expect_start();
    complete_batch(4);
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int i = 0; i < 5; i++) send(DW'(32'hA0 + i));
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_partial: got %0b after 5 x beats, expected 1", busy);
    end
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset_mid");
    exp_q.delete();
    beat_n = 0;
    reset = 1'b1;
    s0 = start_cnt;
    load_vectors(1'b0);
    expect_start();
    complete_batch(3);
    total++;
    if (start_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL reset_mid_starts: got %0d start pulses, expected 1", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = start_cnt;
    for (int b = 0; b < 2; b++) begin
      load_vectors(1'b0);
      expect_start();
      complete_batch(2 + b);
    end
    total++;
    if (start_cnt - s0 !== 2) begin
      bad++;
      $display("FAIL b2b_starts: got %0d start pulses, expected 2", start_cnt - s0);
    end
  endtask

  task automatic test_vector_one();
    in_valid1 = 1'b1;
    in_data1  = 32'hCAFE_0001;
    @(negedge clock);
    total++;
    if (x_wr_en1 !== 1'b1 || x_wr_addr1 !== '0 || x_din1 !== 32'hCAFE_0001 || in_ready1 !== 1'b1 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL vs1_x: en=%0b addr=%0d data=%h rdy=%0b busy=%0b, expected 1 0 cafe0001 1 1",
               x_wr_en1, x_wr_addr1, x_din1, in_ready1, busy1);
    end
    in_data1 = 32'hCAFE_0002;
    @(negedge clock);
    in_valid1 = 1'b0;
    total++;
    if (y_wr_en1 !== 1'b1 || x_wr_en1 !== 1'b0 || y_wr_addr1 !== '0 || y_din1 !== 32'hCAFE_0002 ||
        in_ready1 !== 1'b0 || start1 !== 1'b0) begin
      bad++;
      $display("FAIL vs1_y: yen=%0b xen=%0b addr=%0d data=%h rdy=%0b start=%0b, expected 1 0 0 cafe0002 0 0",
               y_wr_en1, x_wr_en1, y_wr_addr1, y_din1, in_ready1, start1);
    end
    @(negedge clock);
    total++;
    if (start1 !== 1'b1 || y_wr_en1 !== 1'b0) begin
      bad++;
      $display("FAIL vs1_start: start=%0b yen=%0b, expected 1 0", start1, y_wr_en1);
    end
    done1 = 1'b0;
    @(negedge clock);
    done1 = 1'b1;
    @(negedge clock);
    total++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || start1 !== 1'b0) begin
      bad++;
      $display("FAIL vs1_done: busy=%0b rdy=%0b start=%0b, expected 0 1 0", busy1, in_ready1, start1);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_vector_one();
    repeat (3) @(negedge clock);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
